asym_fifo: RTL and testbench

ASYM_FIFO -- requirements
Module: asym_fifo

---
 rtl/asym_fifo_pkg.sv | 16 +
 rtl/asym_fifo_ram.sv | 37 +++
 rtl/asym_fifo.sv | 104 ++++++++++
 tb/tb_asym_fifo.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/asym_fifo_pkg.sv
// Shared helpers for the asymmetric-width FIFO: address sizing and port/storage ratios.
package asym_fifo_pkg;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return res;
    endfunction

    // Number of storage words that make up one port-wide beat.
    function automatic int ratio(input int port_width, input int mem_width);
        return port_width / mem_width;
    endfunction

endpackage

// File: rtl/asym_fifo_ram.sv
// Word-addressed storage: WW-word write port, combinational RW-word read port, both wrapping.
module asym_fifo_ram
    import asym_fifo_pkg::*;
#(
    parameter int MEM_WIDTH = 16,
    parameter int DEPTH     = 16,
    parameter int WW        = 1,
    parameter int RW        = 4,
    parameter int AW        = clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [WW*MEM_WIDTH-1:0] wdata,
    input  logic [AW-1:0]           raddr,
    output logic [RW*MEM_WIDTH-1:0] rdata
);

    logic [MEM_WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately never reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WW; i++) begin
                mem_q[waddr + AW'(i)] <= wdata[i*MEM_WIDTH +: MEM_WIDTH];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < RW; i++) begin
            rdata[i*MEM_WIDTH +: MEM_WIDTH] = mem_q[raddr + AW'(i)];
        end
    end

endmodule

// File: rtl/asym_fifo.sv
// Single-clock FIFO with independent write/read widths, first-word-fall-through read,
// word-granular occupancy and sticky overflow/underflow flags.
module asym_fifo
    import asym_fifo_pkg::*;
#(
    parameter int W_DATA_WIDTH = 16,
    parameter int R_DATA_WIDTH = 64,
    parameter int MEM_WIDTH    = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        wr_en,
    input  logic [W_DATA_WIDTH-1:0]     wr_data,
    output logic                        wr_ready,
    input  logic                        rd_en,
    output logic [R_DATA_WIDTH-1:0]     rd_data,
    output logic                        rd_valid,
    output logic [clog2(FIFO_DEPTH):0]  count,
    output logic                        ovf_err,
    output logic                        udf_err
);

    localparam int ADDR_WIDTH = clog2(FIFO_DEPTH);
    localparam int WW         = ratio(W_DATA_WIDTH, MEM_WIDTH);
    localparam int RW         = ratio(R_DATA_WIDTH, MEM_WIDTH);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] WW_C    = (ADDR_WIDTH+1)'(WW);
    localparam logic [ADDR_WIDTH:0] RW_C    = (ADDR_WIDTH+1)'(RW);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  push, pop;
    logic [R_DATA_WIDTH-1:0] ram_rdata;

    // Handshakes depend only on registered occupancy, so a pop never frees room for a same-cycle push.
    assign wr_ready = (count_q <= DEPTH_C - WW_C);
    assign rd_valid = (count_q >= RW_C);
    assign push     = wr_en && wr_ready;
    assign pop      = rd_en && rd_valid;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(WW);
            if (pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(RW);
            count_d = count_q + (push ? WW_C : '0) - (pop ? RW_C : '0);
            if (wr_en && !wr_ready) ovf_d = 1'b1;
            if (rd_en && !rd_valid) udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    asym_fifo_ram #(
        .MEM_WIDTH (MEM_WIDTH),
        .DEPTH     (FIFO_DEPTH),
        .WW        (WW),
        .RW        (RW),
        .AW        (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (push && !clear && !reset),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign rd_data = rd_valid ? ram_rdata : '0;
    assign count   = count_q;
    assign ovf_err = ovf_q;
    assign udf_err = udf_q;

endmodule

// File: tb/tb_asym_fifo.sv
// Checks an up-converting (16->64) and a down-converting (64->16) FIFO against a word-queue model.
module tb_asym_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // DUT A: 16-bit write, 64-bit read
    logic        a_rst = 1'b0, a_clr = 1'b0, a_we = 1'b0, a_re = 1'b0;
    logic [15:0] a_wd = '0;
    logic        a_rdy, a_vld, a_ovf, a_udf;
    logic [63:0] a_rd;
    logic [4:0]  a_cnt;

    asym_fifo #(.W_DATA_WIDTH(16), .R_DATA_WIDTH(64), .MEM_WIDTH(16), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .reset(a_rst), .clear(a_clr), .wr_en(a_we), .wr_data(a_wd),
        .wr_ready(a_rdy), .rd_en(a_re), .rd_data(a_rd), .rd_valid(a_vld),
        .count(a_cnt), .ovf_err(a_ovf), .udf_err(a_udf)
    );

    // DUT B: 64-bit write, 16-bit read
    logic        b_rst = 1'b0, b_clr = 1'b0, b_we = 1'b0, b_re = 1'b0;
    logic [63:0] b_wd = '0;
    logic        b_rdy, b_vld, b_ovf, b_udf;
    logic [15:0] b_rd;
    logic [4:0]  b_cnt;

    asym_fifo #(.W_DATA_WIDTH(64), .R_DATA_WIDTH(16), .MEM_WIDTH(16), .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .reset(b_rst), .clear(b_clr), .wr_en(b_we), .wr_data(b_wd),
        .wr_ready(b_rdy), .rd_en(b_re), .rd_data(b_rd), .rd_valid(b_vld),
        .count(b_cnt), .ovf_err(b_ovf), .udf_err(b_udf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs, clock once, and return at the following falling edge for sampling.
    task automatic step_a(input logic rst, input logic clr, input logic we, input logic re,
                          input logic [15:0] wd);
        a_rst = rst; a_clr = clr; a_we = we; a_re = re; a_wd = wd;
        @(posedge clk);
        @(negedge clk);
        a_rst = 1'b0; a_clr = 1'b0; a_we = 1'b0; a_re = 1'b0;
    endtask

    task automatic step_b(input logic rst, input logic we, input logic re, input logic [63:0] wd);
        b_rst = rst; b_we = we; b_re = re; b_wd = wd;
        @(posedge clk);
        @(negedge clk);
        b_rst = 1'b0; b_we = 1'b0; b_re = 1'b0;
    endtask

    task automatic check_a(input string tag, input logic [4:0] cnt, input logic rdy,
                           input logic vld, input logic [63:0] rd, input logic ovf, input logic udf);
        check({tag, ".count"},    64'(a_cnt), 64'(cnt));
        check({tag, ".wr_ready"}, 64'(a_rdy), 64'(rdy));
        check({tag, ".rd_valid"}, 64'(a_vld), 64'(vld));
        check({tag, ".rd_data"},  a_rd, rd);
        check({tag, ".ovf_err"},  64'(a_ovf), 64'(ovf));
        check({tag, ".udf_err"},  64'(a_udf), 64'(udf));
    endtask

    typedef struct {
        logic        rst, clr, we, re;
        logic [15:0] wd;
        logic [4:0]  cnt;
        logic        rdy, vld;
        logic [63:0] rd;
        logic        ovf, udf;
    } vec_t;

    localparam int NV = 14;
    vec_t tv [NV];

    // Reference model: a plain queue of 16-bit words plus sticky flags.
    logic [15:0] mq [$];
    logic        m_ovf, m_udf;

    initial begin
        // rst clr we re  wd        cnt  rdy vld rd                      ovf udf
        tv[0]  = '{1, 0, 0, 0, 16'h0000, 5'd0, 1, 0, 64'h0,                  0, 0};
        tv[1]  = '{0, 0, 0, 1, 16'h0000, 5'd0, 1, 0, 64'h0,                  0, 1};
        tv[2]  = '{0, 0, 1, 0, 16'h0001, 5'd1, 1, 0, 64'h0,                  0, 1};
        tv[3]  = '{0, 0, 1, 0, 16'h0002, 5'd2, 1, 0, 64'h0,                  0, 1};
        tv[4]  = '{0, 0, 1, 0, 16'h0003, 5'd3, 1, 0, 64'h0,                  0, 1};
        tv[5]  = '{0, 0, 1, 0, 16'h0004, 5'd4, 1, 1, 64'h0004_0003_0002_0001, 0, 1};
        tv[6]  = '{0, 0, 1, 1, 16'h0005, 5'd1, 1, 0, 64'h0,                  0, 1};
        tv[7]  = '{0, 0, 1, 0, 16'h0006, 5'd2, 1, 0, 64'h0,                  0, 1};
        tv[8]  = '{0, 0, 1, 0, 16'h0007, 5'd3, 1, 0, 64'h0,                  0, 1};
        tv[9]  = '{0, 0, 1, 0, 16'h0008, 5'd4, 1, 1, 64'h0008_0007_0006_0005, 0, 1};
        tv[10] = '{0, 1, 1, 1, 16'h00AA, 5'd0, 1, 0, 64'h0,                  0, 0};
        tv[11] = '{0, 0, 1, 0, 16'h0011, 5'd1, 1, 0, 64'h0,                  0, 0};
        tv[12] = '{0, 0, 0, 1, 16'h0000, 5'd1, 1, 0, 64'h0,                  0, 1};
        tv[13] = '{1, 0, 1, 0, 16'h0012, 5'd0, 1, 0, 64'h0,                  0, 0};

        b_rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            step_a(tv[i].rst, tv[i].clr, tv[i].we, tv[i].re, tv[i].wd);
            if (i == 0) b_rst = 1'b0;
            check_a($sformatf("vec%0d", i), tv[i].cnt, tv[i].rdy, tv[i].vld, tv[i].rd,
                    tv[i].ovf, tv[i].udf);
        end

        // Fill to capacity, then one more push must be dropped.
        for (int i = 0; i < 16; i++) step_a(0, 0, 1, 0, 16'h0100 + 16'(i));
        check_a("full", 5'd16, 0, 1, 64'h0103_0102_0101_0100, 0, 0);
        step_a(0, 0, 1, 0, 16'hDEAD);
        check_a("overfill", 5'd16, 0, 1, 64'h0103_0102_0101_0100, 1, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d", i), a_rd,
                  {16'h0103 + 16'(4*i), 16'h0102 + 16'(4*i), 16'h0101 + 16'(4*i), 16'h0100 + 16'(4*i)});
            step_a(0, 0, 0, 1, 16'h0);
        end
        check_a("drained", 5'd0, 1, 0, 64'h0, 1, 0);

        // Clear mid-burst while pushes and pops are requested.
        for (int i = 0; i < 6; i++) step_a(0, 0, 1, 0, 16'h0200 + 16'(i));
        step_a(0, 1, 1, 1, 16'h0300);
        check_a("clear_burst", 5'd0, 1, 0, 64'h0, 0, 0);

        // Down-conversion: one wide push, four narrow pops in little-endian order.
        step_b(0, 1, 0, 64'h0004_0003_0002_0001);
        check("dn.count", 64'(b_cnt), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dn.valid%0d", i), 64'(b_vld), 64'd1);
            check($sformatf("dn.data%0d", i), 64'(b_rd), 64'(i + 1));
            step_b(0, 0, 1, 64'h0);
        end
        check("dn.empty_valid", 64'(b_vld), 64'd0);
        check("dn.empty_data",  64'(b_rd), 64'd0);
        check("dn.udf_clean",   64'(b_udf), 64'd0);
        step_b(1, 1, 0, 64'h0);
        check("dn.reset_count", 64'(b_cnt), 64'd0);

        // Randomized traffic against the queue model; phases bias toward filling or draining.
        step_a(1, 0, 0, 0, 16'h0);
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            logic [63:0] exp_rd;
            logic        m_rdy, m_vld, we, re, clr, rst;
            logic [15:0] wd;
            int          wr_pct;
            m_rdy = (mq.size() <= 15);
            m_vld = (mq.size() >= 4);
            exp_rd = '0;
            if (m_vld) for (int k = 0; k < 4; k++) exp_rd[k*16 +: 16] = mq[k];
            check("rnd.count",    64'(a_cnt), 64'(mq.size()));
            check("rnd.wr_ready", 64'(a_rdy), 64'(m_rdy));
            check("rnd.rd_valid", 64'(a_vld), 64'(m_vld));
            check("rnd.rd_data",  a_rd, exp_rd);
            check("rnd.ovf_err",  64'(a_ovf), 64'(m_ovf));
            check("rnd.udf_err",  64'(a_udf), 64'(m_udf));
            if (bad > 20) break;

            wr_pct = ((cyc / 100) % 2 == 0) ? 75 : 30;
            we  = ($urandom_range(99) < wr_pct);
            re  = ($urandom_range(99) < 100 - wr_pct);
            wd  = 16'($urandom);
            clr = ($urandom_range(199) == 0);
            rst = ($urandom_range(299) == 0);

            if (rst || clr) begin
                mq.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                if (we && !m_rdy) m_ovf = 1'b1;
                if (re && !m_vld) m_udf = 1'b1;
                if (re && m_vld) for (int k = 0; k < 4; k++) void'(mq.pop_front());
                if (we && m_rdy) mq.push_back(wd);
            end
            step_a(rst, clr, we, re, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
